// File: rtl/led_scan_ctrl_if.sv
// Value handshake between the CPU-side LED register and led_scan_ctrl.
// The master drives a value and blanking mode; the slave reports readiness, busy and the committed digits.
interface led_scan_ctrl_if;
   logic [31:0] value_in;
   logic        value_valid;
   logic        value_ready;
   logic        blank_lz;
   logic        busy;
   logic [31:0] bcd_out;

   modport master (
      output value_in,
      output value_valid,
      output blank_lz,
      input  value_ready,
      input  busy,
      input  bcd_out
   );

   modport slave (
      input  value_in,
      input  value_valid,
      input  blank_lz,
      output value_ready,
      output busy,
      output bcd_out
   );
endinterface

// File: rtl/led_scan_ctrl.sv
// 8-digit seven-segment controller: iterative binary-to-BCD conversion (shift-add-3)
// feeding a free-running multiplexed digit scanner with optional leading-zero blanking.
module led_scan_ctrl #(
   parameter int CLK_DIV        = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   led_scan_ctrl_if.slave bus,
   output logic [7:0]     an,
   output logic [6:0]     seg,
   output logic           dp
);

   localparam int            CW      = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [7:0]    AN_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic          DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        ready_state;
   logic        busy_state;
   logic        value_ready_int;
   logic        accept;

   logic [31:0] bin_reg;
   logic [31:0] acc_reg;
   logic [4:0]  bitcnt_reg;
   logic [31:0] bcd_reg;
   logic [31:0] acc_adj;
   logic [63:0] dabble_shift;

   logic [CW-1:0] cnt_reg;
   logic [2:0]    idx_reg;
   logic [7:0]    digit_nz;
   logic [2:0]    top_digit;
   logic [3:0]    digit_sel;
   logic          digit_blank;
   logic [6:0]    seg_on;
   logic [7:0]    an_on;
   logic [7:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_reg;

   genvar gi;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = CONV;
         CONV:    if (bitcnt_reg == 5'd0) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_state = 1'b0;
      busy_state  = 1'b0;
      unique case (state_reg)
         IDLE:    ready_state = 1'b1;
         CONV:    busy_state  = 1'b1;
         default: ;
      endcase
   end

   // Ready is held low for as long as reset is asserted, not only after the reset edge.
   assign value_ready_int = ready_state & rst_n;
   assign accept          = bus.value_valid & value_ready_int;
   assign bus.value_ready = value_ready_int;
   assign bus.busy        = busy_state;
   assign bus.bcd_out     = bcd_reg;

   // ---------------- double-dabble datapath ----------------
   generate
      for (gi = 0; gi < 8; gi++) begin : g_adj
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     (acc_reg[4*gi +: 4] + 4'd3) : acc_reg[4*gi +: 4];
      end
   endgenerate

   // The carry out of the top nibble falls off the end, which yields value mod 10^8.
   assign dabble_shift = {acc_adj, bin_reg} << 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_reg    <= '0;
         acc_reg    <= '0;
         bitcnt_reg <= '0;
         bcd_reg    <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (accept) begin
                  bin_reg    <= bus.value_in;
                  acc_reg    <= '0;
                  bitcnt_reg <= 5'd31;
               end
            end
            CONV: begin
               acc_reg    <= dabble_shift[63:32];
               bin_reg    <= dabble_shift[31:0];
               bitcnt_reg <= bitcnt_reg - 5'd1;
            end
            COMMIT: begin
               bcd_reg <= acc_reg;
            end
            default: ;
         endcase
      end
   end

   // ---------------- digit scanner ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
         cnt_reg <= '0;
         idx_reg <= idx_reg + 3'd1;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   generate
      for (gi = 0; gi < 8; gi++) begin : g_nz
         assign digit_nz[gi] = |bcd_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      top_digit = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (digit_nz[i]) top_digit = 3'(i);
      end
   end

   // Digit 0 is never blanked since top_digit is at least 0.
   assign digit_sel   = bcd_reg[4*idx_reg +: 4];
   assign digit_blank = bus.blank_lz && (idx_reg > top_digit);
   assign an_on       = 8'd1 << idx_reg;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
   always_comb begin
      seg_on = 7'h00;
      if (!digit_blank) begin
         unique case (digit_sel)
            4'd0:    seg_on = 7'h3F;
            4'd1:    seg_on = 7'h06;
            4'd2:    seg_on = 7'h5B;
            4'd3:    seg_on = 7'h4F;
            4'd4:    seg_on = 7'h66;
            4'd5:    seg_on = 7'h6D;
            4'd6:    seg_on = 7'h7D;
            4'd7:    seg_on = 7'h07;
            4'd8:    seg_on = 7'h7F;
            4'd9:    seg_on = 7'h6F;
            default: seg_on = 7'h00;
         endcase
      end
   end

   // XOR with the "off" pattern applies the pin polarity in one place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_reg  <= AN_OFF;
         seg_reg <= SEG_OFF;
         dp_reg  <= DP_OFF;
      end else begin
         an_reg  <= an_on ^ AN_OFF;
         seg_reg <= seg_on ^ SEG_OFF;
         dp_reg  <= DP_OFF;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = dp_reg;

endmodule
